// File: rtl/ym_sr_slot_bank_pkg.sv
// Shared definitions for the TDM slot bank: standard slot counts, the stage-0
// input selector and a ceil-log2 helper used to validate the counter width.
package ym_sr_slot_bank_pkg;

  localparam int YM_OP_SLOTS = 24;
  localparam int YM_CH_SLOTS = 6;

  typedef enum logic [1:0] {
    IN_ZERO   = 2'd0,
    IN_WRITE  = 2'd1,
    IN_RECIRC = 2'd2
  } in_sel_e;

  function automatic int ym_clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/ym_sr_slot_stage.sv
// One ring stage: a DATA_WIDTH master/slave pair. The master captures on c1 and the
// slave takes the master on c2; both read pre-edge values, so nothing flows through.
module ym_sr_slot_stage #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  c1,
  input  logic                  c2,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] m_q, m_d;
  logic [DATA_WIDTH-1:0] s_q, s_d;

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (c1) m_d = d;
    if (c2) s_d = m_q;
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  assign q = s_q;

endmodule

// File: rtl/ym_sr_slot_bank.sv
// Time-division-multiplexed register bank: SLOTS words rotate through a master/slave
// ring, one stage per c2, with a slot counter tagging the word presented on rd_data.
module ym_sr_slot_bank
  import ym_sr_slot_bank_pkg::*;
#(
  parameter int SLOTS      = YM_OP_SLOTS,
  parameter int DATA_WIDTH = 10,
  parameter int TAP        = 12,
  parameter int CNT_W      = 5
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  recirc,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic                  sync,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tap_data,
  output logic [CNT_W-1:0]      slot,
  output logic                  frame_end
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

  if (SLOTS < 2 || DATA_WIDTH < 1 || TAP < 0 || TAP >= SLOTS ||
      CNT_W < ym_clog2(SLOTS)) begin : g_param_err
    $error("ym_sr_slot_bank: illegal parameters SLOTS=%0d TAP=%0d CNT_W=%0d",
           SLOTS, TAP, CNT_W);
  end

  logic [DATA_WIDTH-1:0] stage_out [SLOTS];
  logic [DATA_WIDTH-1:0] in0;
  in_sel_e               in_sel;
  logic [CNT_W-1:0]      slot_q, slot_d;

  // clr beats wr_en beats recirc; with none of them the ring drains to zero
  always_comb begin
    in_sel = IN_ZERO;
    if (clr) begin
      in_sel = IN_ZERO;
    end else if (wr_en) begin
      in_sel = IN_WRITE;
    end else if (recirc) begin
      in_sel = IN_RECIRC;
    end
    in0 = '0;
    case (in_sel)
      IN_WRITE:  in0 = wr_data;
      IN_RECIRC: in0 = stage_out[SLOTS-1];
      default:   in0 = '0;
    endcase
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_stage
    logic [DATA_WIDTH-1:0] stage_in;
    if (g == 0) begin : g_head
      assign stage_in = in0;
    end else begin : g_body
      assign stage_in = stage_out[g-1];
    end
    ym_sr_slot_stage #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_stage (
      .MCLK  (MCLK),
      .reset (reset),
      .c1    (c1),
      .c2    (c2),
      .d     (stage_in),
      .q     (stage_out[g])
    );
  end

  // Compare-and-wrap keeps non-power-of-two slot counts inside 0..SLOTS-1
  always_comb begin
    slot_d = slot_q;
    if (c2) begin
      if (sync || slot_q == LAST_SLOT) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rd_data   = stage_out[SLOTS-1];
  assign tap_data  = stage_out[TAP];
  assign slot      = slot_q;
  assign frame_end = (slot_q == LAST_SLOT);

endmodule

// File: tb/tb_ym_sr_slot_bank.sv
// Directed bench for ym_sr_slot_bank: a 24-slot/10-bit instance plus a 6-slot/1-bit
// instance, checked against a per-slot tag model of what each slot should hold.
module tb_ym_sr_slot_bank;
  import ym_sr_slot_bank_pkg::*;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic       reset;
  logic       c1, c2, recirc, wr_en, clr, sync;
  logic [9:0] wr_data;
  logic [9:0] rd_data, tap_data;
  logic [4:0] slot;
  logic       frame_end;

  logic       c1_s, c2_s, recirc_s, wr_en_s, clr_s, sync_s;
  logic [0:0] wr_data_s, rd_s, tap_s;
  logic [2:0] slot_s;
  logic       fe_s;

  ym_sr_slot_bank #(.SLOTS(YM_OP_SLOTS), .DATA_WIDTH(10), .TAP(12), .CNT_W(5)) dut (
    .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .recirc(recirc), .wr_en(wr_en),
    .wr_data(wr_data), .clr(clr), .sync(sync), .rd_data(rd_data), .tap_data(tap_data),
    .slot(slot), .frame_end(frame_end)
  );

  ym_sr_slot_bank #(.SLOTS(YM_CH_SLOTS), .DATA_WIDTH(1), .TAP(2), .CNT_W(3)) dut6 (
    .MCLK(MCLK), .reset(reset), .c1(c1_s), .c2(c2_s), .recirc(recirc_s), .wr_en(wr_en_s),
    .wr_data(wr_data_s), .clr(clr_s), .sync(sync_s), .rd_data(rd_s), .tap_data(tap_s),
    .slot(slot_s), .frame_end(fe_s)
  );

  int         total = 0;
  int         bad = 0;
  int         exp_slot;
  logic [9:0] mem [24];
  int         exp_slot6;
  logic       mem6 [6];

  typedef struct {
    logic       c1, c2, recirc, wr_en;
    logic [9:0] wr_data;
    logic       clr, sync;
    logic [9:0] exp_rd, exp_tap;
    logic [4:0] exp_slot;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c1v, input logic c2v, input logic recv, input logic wrv,
                               input logic [9:0] wd, input logic clrv, input logic syncv);
    c1 = c1v; c2 = c2v; recirc = recv; wr_en = wrv; wr_data = wd; clr = clrv; sync = syncv;
    @(posedge MCLK);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    c1 = 0; c2 = 0; recirc = 0; wr_en = 0; wr_data = '0; clr = 0; sync = 0;
    c1_s = 0; c2_s = 0; recirc_s = 0; wr_en_s = 0; wr_data_s = '0; clr_s = 0; sync_s = 0;
    repeat (2) @(posedge MCLK);
    #1;
    reset = 1'b1;
    exp_slot = 0;
    exp_slot6 = 0;
    for (int k = 0; k < 24; k++) mem[k] = '0;
    for (int k = 0; k < 6; k++) mem6[k] = 1'b0;
  endtask

  // One c1 cycle then one c2 cycle; the model records what slot exp_slot now holds
  task automatic pairStep(input logic recv, input logic wrv, input logic [9:0] wd, input logic clrv);
    if (clrv) mem[exp_slot] = '0;
    else if (wrv) mem[exp_slot] = wd;
    else if (!recv) mem[exp_slot] = '0;
    applyStimulus(1, 0, recv, wrv, wd, clrv, 0);
    applyStimulus(0, 1, recv, 0, '0, 0, 0);
    exp_slot = (exp_slot + 1) % 24;
  endtask

  task automatic checkRing(input string tag);
    checkOutput({tag, "_slot"}, 32'(slot), 32'(exp_slot));
    checkOutput({tag, "_rd"}, 32'(rd_data), 32'(mem[exp_slot]));
    checkOutput({tag, "_tap"}, 32'(tap_data), 32'(mem[(exp_slot + 24 - 13) % 24]));
  endtask

  task automatic pairStep6(input logic wrv, input logic wd);
    if (wrv) mem6[exp_slot6] = wd;
    c1_s = 1; c2_s = 0; recirc_s = 1; wr_en_s = wrv; wr_data_s = wd;
    @(posedge MCLK); #1;
    c1_s = 0; c2_s = 1; wr_en_s = 0; wr_data_s = '0;
    @(posedge MCLK); #1;
    c2_s = 0;
    exp_slot6 = (exp_slot6 + 1) % 6;
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd0, 1'b0};
    vecs[1] = '{1, 0, 0, 1, 10'h155, 0, 0, 10'h000, 10'h000, 5'd0, 1'b0};
    vecs[2] = '{0, 1, 0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd1, 1'b0};
    vecs[3] = '{1, 1, 0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd2, 1'b0};
    vecs[4] = '{0, 1, 1, 0, 10'h000, 0, 1, 10'h000, 10'h000, 5'd0, 1'b0};
    vecs[5] = '{0, 1, 1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd1, 1'b0};
    vecs[6] = '{1, 0, 1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd1, 1'b0};
    vecs[7] = '{0, 0, 1, 0, 10'h000, 0, 1, 10'h000, 10'h000, 5'd1, 1'b0};
    vecs[8] = '{0, 1, 1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 5'd2, 1'b0};

    doReset();
    checkOutput("reset_rd", 32'(rd_data), 0);
    checkOutput("reset_slot", 32'(slot), 0);
    checkOutput("reset_fe", 32'(frame_end), 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].c1, vecs[i].c2, vecs[i].recirc, vecs[i].wr_en, vecs[i].wr_data,
                    vecs[i].clr, vecs[i].sync);
      checkOutput($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_tap", i), 32'(tap_data), 32'(vecs[i].exp_tap));
      checkOutput($sformatf("vec%0d_slot", i), 32'(slot), 32'(vecs[i].exp_slot));
      checkOutput($sformatf("vec%0d_fe", i), 32'(frame_end), 32'(vecs[i].exp_fe));
    end

    // Counter wrap and sync realignment
    doReset();
    repeat (23) applyStimulus(0, 1, 0, 0, '0, 0, 0);
    checkOutput("cnt_23_slot", 32'(slot), 23);
    checkOutput("cnt_23_fe", 32'(frame_end), 1);
    applyStimulus(0, 1, 0, 0, '0, 0, 0);
    checkOutput("cnt_wrap_slot", 32'(slot), 0);
    checkOutput("cnt_wrap_fe", 32'(frame_end), 0);
    repeat (10) applyStimulus(0, 1, 0, 0, '0, 0, 0);
    checkOutput("cnt_10_slot", 32'(slot), 10);
    applyStimulus(0, 1, 0, 0, '0, 0, 1);
    checkOutput("cnt_sync_slot", 32'(slot), 0);

    // Single write at slot 5 recirculates with a period of 24 c2 phases
    doReset();
    while (exp_slot != 5) pairStep(1, 0, '0, 0);
    pairStep(1, 1, 10'h2A5, 0);
    for (int i = 0; i < 48; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("wr5_p%0d", i));
    end

    // Drain with recirc off, then clr must beat wr_en
    for (int i = 0; i < 24; i++) pairStep(0, 0, '0, 0);
    for (int i = 0; i < 24; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("drain_p%0d", i));
    end
    while (exp_slot != 3) pairStep(1, 0, '0, 0);
    pairStep(1, 1, 10'h155, 0);
    for (int i = 0; i < 24; i++) pairStep(1, 0, '0, 0);
    checkRing("pre_clr");
    pairStep(1, 1, 10'h3FF, 1);
    for (int i = 0; i < 24; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("clr_p%0d", i));
    end

    // Reset mid-run with the ring full of 0x3FF
    for (int i = 0; i < 24; i++) pairStep(1, 1, 10'h3FF, 0);
    while (exp_slot != 23) pairStep(1, 0, '0, 0);
    checkRing("full");
    checkOutput("full_fe", 32'(frame_end), 1);
    reset = 1'b0;
    #2;
    checkOutput("arst_rd", 32'(rd_data), 0);
    checkOutput("arst_tap", 32'(tap_data), 0);
    checkOutput("arst_slot", 32'(slot), 0);
    checkOutput("arst_fe", 32'(frame_end), 0);
    reset = 1'b1;
    exp_slot = 0;
    for (int k = 0; k < 24; k++) mem[k] = '0;
    for (int i = 0; i < 24; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("post_rst_p%0d", i));
    end

    // Distinct words everywhere; 48 cycles of c1+c2 together must land where they started
    doReset();
    for (int k = 0; k < 24; k++) pairStep(1, 1, 10'((k * 37 + 5) & 10'h3FF), 0);
    for (int i = 0; i < 24; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("alt_p%0d", i));
    end
    for (int i = 0; i < 48; i++) begin
      applyStimulus(1, 1, 1, 0, '0, 0, 0);
      exp_slot = (exp_slot + 1) % 24;
    end
    checkRing("both48");
    for (int i = 0; i < 24; i++) begin
      pairStep(1, 0, '0, 0);
      checkRing($sformatf("both_p%0d", i));
    end

    // Small 6-slot, 1-bit instance with tap at stage 2
    doReset();
    pairStep6(1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      pairStep6(0, 1'b0);
      checkOutput($sformatf("s6_p%0d_slot", i), 32'(slot_s), 32'(exp_slot6));
      checkOutput($sformatf("s6_p%0d_rd", i), 32'(rd_s), 32'(mem6[exp_slot6]));
      checkOutput($sformatf("s6_p%0d_tap", i), 32'(tap_s), 32'(mem6[(exp_slot6 + 3) % 6]));
      checkOutput($sformatf("s6_p%0d_fe", i), 32'(fe_s), 32'(exp_slot6 == 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
